counter_scheduler_4bit: RTL and testbench

COUNTER_SCHEDULER_4BIT -- requirements
Module: counter_scheduler_4bit

---
 rtl/counter_scheduler_4bit.sv | 95 +++++++++
 tb/tb_counter_scheduler_4bit.sv | 133 +++++++++++++
 2 files changed

// File: rtl/counter_scheduler_4bit.sv
// Two-requester round-robin scheduler sharing one up-counter (IDLE -> RUN -> DONE).
// Optional requester abort during RUN is enabled by defining SCHED_ABORT_EN.
module counter_scheduler_4bit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic [1:0]   req,
    input  logic [W-1:0] len0,
    input  logic [W-1:0] len1,
    output logic [1:0]   grant,
    output logic [W-1:0] q,
    output logic         busy,
    output logic [1:0]   done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t       state_reg, state_next;
    logic         owner_reg;
    logic         last_reg;
    logic [W-1:0] q_reg;
    logic [W-1:0] target_reg;
    logic         winner;
    logic         abort;

    // Tie goes to the requester that was not granted most recently.
    assign winner = (req == 2'b11) ? ~last_reg : req[1];

`ifdef SCHED_ABORT_EN
    assign abort = ~req[owner_reg];
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            q_reg      <= '0;
            target_reg <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (|req) begin
                        owner_reg  <= winner;
                        last_reg   <= winner;
                        target_reg <= winner ? len1 : len0;
                        q_reg      <= '0;
                    end
                end
                RUN: begin
                    if (abort)
                        q_reg <= '0;
                    else if (q_reg != target_reg)
                        q_reg <= q_reg + 1'b1;
                end
                DONE:    q_reg <= '0;
                default: q_reg <= '0;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (|req) state_next = RUN;
            RUN: begin
                if (abort)
                    state_next = IDLE;
                else if (q_reg == target_reg)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic in_done;

    always_comb begin
        busy    = (state_reg != IDLE);
        in_done = (state_reg == DONE);
        q       = q_reg;
    end

    // One-hot decode of the owner; only one bit can ever be set.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_onehot
            assign grant[gi] = busy    && (owner_reg == 1'(gi));
            assign done[gi]  = in_done && (owner_reg == 1'(gi));
        end
    endgenerate
endmodule

// File: tb/tb_counter_scheduler_4bit.sv
// Randomized bench for counter_scheduler_4bit against a per-grant cycle-index model.
// Honors SCHED_ABORT_EN the same way the design does.
module tb_counter_scheduler_4bit;
    localparam int W = 4;
`ifdef SCHED_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         clear;
    logic [1:0]   req;
    logic [W-1:0] len0, len1;
    logic [1:0]   grant;
    logic [W-1:0] q;
    logic         busy;
    logic [1:0]   done;

    always #5 clk = ~clk;

    counter_scheduler_4bit #(.W(W)) dut (
        .clk(clk), .clear(clear), .req(req), .len0(len0), .len1(len1),
        .grant(grant), .q(q), .busy(busy), .done(done)
    );

    int checks = 0;
    int errors = 0;

    // Model: a grant lasts len+2 cycles indexed k = 0..len+1; q = min(k,len), done at k = len+1.
    bit m_active = 1'b0;
    int m_owner  = 0;
    int m_len    = 0;
    int m_k      = 0;
    int m_last   = 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        if (clear) begin
            m_active = 1'b0;
            m_last   = 1;
        end else if (!m_active) begin
            if (req != 2'b00) begin
                m_owner  = (req == 2'b11) ? (1 - m_last) : (req[1] ? 1 : 0);
                m_last   = m_owner;
                m_len    = (m_owner == 1) ? int'(len1) : int'(len0);
                m_k      = 0;
                m_active = 1'b1;
            end
        end else if (ABORT_EN && m_k <= m_len && !req[m_owner]) begin
            m_active = 1'b0;
            $display("txn owner=%0d len=%0d aborted at q=%0d", m_owner, m_len, m_k);
        end else if (m_k == m_len + 1) begin
            m_active = 1'b0;
            $display("txn owner=%0d len=%0d completed", m_owner, m_len);
        end else begin
            m_k++;
        end
    endtask

    task automatic step(input logic c, input logic [1:0] r, input int l0, input int l1);
        logic [1:0] eg, ed;
        int eq;
        @(negedge clk);
        clear = c;
        req   = r;
        len0  = W'(l0);
        len1  = W'(l1);
        @(posedge clk);
        model_update();
        #1;
        eg = m_active ? 2'(1 << m_owner) : 2'b00;
        ed = (m_active && m_k == m_len + 1) ? 2'(1 << m_owner) : 2'b00;
        eq = m_active ? ((m_k < m_len) ? m_k : m_len) : 0;
        check_val("grant", 32'(grant), 32'(eg));
        check_val("q",     32'(q),     32'(eq));
        check_val("busy",  32'(busy),  32'(m_active));
        check_val("done",  32'(done),  32'(ed));
    endtask

    initial begin
        clear = 1'b1;
        req   = 2'b00;
        len0  = '0;
        len1  = '0;

        // Basic count of 3 after a two-cycle clear.
        step(1, 2'b00, 0, 0);
        step(1, 2'b00, 0, 0);
        for (int i = 0; i < 7; i++) step(0, (i == 0) ? 2'b01 : 2'b00, 3, 0);

        // Contention: alternating grants, lengths changed mid-run must not matter.
        step(1, 2'b00, 0, 0);
        for (int i = 0; i < 16; i++) step(0, 2'b11, (i == 3) ? 9 : 2, (i == 3) ? 7 : 1);

        // Zero-length request and full-range count.
        step(1, 2'b00, 0, 0);
        for (int i = 0; i < 4; i++)  step(0, (i == 0) ? 2'b10 : 2'b00, 5, 0);
        for (int i = 0; i < 20; i++) step(0, 2'b01, 15, 0);

        // Clear in the middle of a run.
        step(1, 2'b00, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 2'b01, 10, 0);
        step(1, 2'b01, 10, 0);
        step(0, 2'b00, 10, 0);

        // Requester drops its request mid-count.
        for (int i = 0; i < 4; i++)  step(0, 2'b01, 8, 0);
        for (int i = 0; i < 10; i++) step(0, 2'b00, 8, 0);

        // Random traffic with sticky requests and occasional clears.
        begin
            logic [1:0] r;
            r = 2'b00;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 7) == 0) r = 2'($urandom_range(0, 3));
                step(($urandom_range(0, 59) == 0), r,
                     ($urandom_range(0, 3) == 0) ? 15 * $urandom_range(0, 1) : $urandom_range(0, 15),
                     ($urandom_range(0, 3) == 0) ? 15 * $urandom_range(0, 1) : $urandom_range(0, 15));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
